req_priority_arbiter: RTL and testbench

//  Sequential 4-requester arbiter built around the 4-to-2 priority encode

---
 rtl/req_priority_arbiter.sv | 143 ++++++++++++++
 tb/tb_req_priority_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/req_priority_arbiter.sv
// Four-requester arbiter that shares one resource. It offers fixed or round-robin priority,
// holds a grant up to MAX_HOLD cycles and leaves one dead cycle between grants.
module req_priority_arbiter #(
   parameter int RR_MODE  = 0,
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       grant_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Wraps to all-ones when MAX_HOLD is 0; the compare is gated off in that case.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [1:0]       id_q, id_d;
   logic             valid_q, valid_d;
   logic             to_q, to_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [7:0]       dbl_s;
   logic [3:0]       rot_s;
   logic [2:0]       enc_s;
   logic [1:0]       win_s;
   logic             win_vld_s;

   // Returns {found, index} of the highest set bit.
   function automatic logic [2:0] enc_high(input logic [3:0] r);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 0; i < 4; i++) begin
         if (r[i]) res = {1'b1, 2'(i)};
      end
      return res;
   endfunction

   // Returns {found, index} of the lowest set bit.
   function automatic logic [2:0] enc_low(input logic [3:0] r);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (r[i]) res = {1'b1, 2'(i)};
      end
      return res;
   endfunction

   // Winner selection: round-robin rotates req so that rr_ptr becomes bit 0.
   always_comb begin
      dbl_s = {req, req};
      rot_s = dbl_s[ptr_q +: 4];
      if (RR_MODE != 0) begin
         enc_s = enc_low(rot_s);
         win_s = enc_s[1:0] + ptr_q;
      end else begin
         enc_s = enc_high(req);
         win_s = enc_s[1:0];
      end
      win_vld_s = enc_s[2];
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      case (state_q)
         ST_IDLE, ST_GAP: begin
            if (win_vld_s) begin
               state_d = ST_GRANT;
               grant_d = 4'b0001 << win_s;
               id_d    = win_s;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
               grant_d = 4'b0000;
            end
         end
         ST_GRANT: begin
            if (!req[id_q] || ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST))) begin
               // A normal release takes precedence, so timeout only fires while req is still held.
               state_d = ST_GAP;
               grant_d = 4'b0000;
               to_d    = req[id_q];
               if (RR_MODE != 0) begin
                  ptr_d = id_q + 2'd1;
               end else begin
                  ptr_d = ptr_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
         end
      endcase
      valid_d = |grant_d;
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= 4'b0000;
         id_q    <= 2'b00;
         valid_q <= 1'b0;
         to_q    <= 1'b0;
         ptr_q   <= 2'b00;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         valid_q <= valid_d;
         to_q    <= to_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_id    = id_q;
   assign grant_valid = valid_q;
   assign timeout     = to_q;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Bench for req_priority_arbiter: three configurations run against one behavioural model.
// The model tracks owner, hold length and pointer as plain integers.
module tb_req_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_a, req_b, req_c;
   logic [3:0] gnt [3];
   logic [1:0] gid [3];
   logic       gv  [3];
   logic       tmo [3];

   int pass_cnt = 0;
   int tot_cnt  = 0;

   int m_owner [3];
   int m_cnt   [3];
   int m_ptr   [3];
   int m_id    [3];
   bit m_gap   [3];
   bit m_to    [3];

   always #5 clk = ~clk;

   req_priority_arbiter #(.RR_MODE(0), .MAX_HOLD(8), .CNT_W(4)) u_fix (
      .clk(clk), .rst_n(rst_n), .req(req_a),
      .grant(gnt[0]), .grant_id(gid[0]), .grant_valid(gv[0]), .timeout(tmo[0]));
   req_priority_arbiter #(.RR_MODE(1), .MAX_HOLD(4), .CNT_W(4)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req_b),
      .grant(gnt[1]), .grant_id(gid[1]), .grant_valid(gv[1]), .timeout(tmo[1]));
   req_priority_arbiter #(.RR_MODE(0), .MAX_HOLD(0), .CNT_W(4)) u_nt (
      .clk(clk), .rst_n(rst_n), .req(req_c),
      .grant(gnt[2]), .grant_id(gid[2]), .grant_valid(gv[2]), .timeout(tmo[2]));

   function automatic int cfg_rr(input int k);
      return (k == 1) ? 1 : 0;
   endfunction

   function automatic int cfg_mh(input int k);
      case (k)
         0:       return 8;
         1:       return 4;
         default: return 0;
      endcase
   endfunction

   function automatic int pick(input logic [3:0] r, input int rr, input int ptr);
      int w;
      w = -1;
      if (rr != 0) begin
         for (int i = 3; i >= 0; i--) begin
            if (r[(ptr + i) % 4]) w = (ptr + i) % 4;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r[i]) w = i;
         end
      end
      return w;
   endfunction

   task automatic model_step(input int k, input logic [3:0] r);
      int w;
      m_to[k] = 1'b0;
      if (m_owner[k] >= 0) begin
         if (!r[m_owner[k]] || (cfg_mh(k) != 0 && m_cnt[k] == cfg_mh(k) - 1)) begin
            m_to[k]  = r[m_owner[k]];
            if (cfg_rr(k) != 0) m_ptr[k] = (m_owner[k] + 1) % 4;
            m_owner[k] = -1;
            m_gap[k]   = 1'b1;
         end else begin
            m_cnt[k]++;
         end
      end else begin
         m_gap[k] = 1'b0;
         w = pick(r, cfg_rr(k), m_ptr[k]);
         if (w >= 0) begin
            m_owner[k] = w;
            m_cnt[k]   = 0;
            m_id[k]    = w;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1; m_cnt[k] = 0; m_ptr[k] = 0; m_id[k] = 0;
            m_gap[k] = 1'b0; m_to[k] = 1'b0;
         end
      end else begin
         model_step(0, req_a);
         model_step(1, req_b);
         model_step(2, req_c);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic compare_model();
      logic [3:0] eg;
      for (int k = 0; k < 3; k++) begin
         eg = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
         chk($sformatf("model_grant[%0d]", k), int'(gnt[k]), int'(eg));
         chk($sformatf("model_valid[%0d]", k), int'(gv[k]), (m_owner[k] >= 0) ? 1 : 0);
         chk($sformatf("model_timeout[%0d]", k), int'(tmo[k]), int'(m_to[k]));
         if (m_owner[k] >= 0 || m_gap[k])
            chk($sformatf("model_id[%0d]", k), int'(gid[k]), m_id[k]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 4'b1111; req_b = 4'b1111; req_c = 4'b1111;
      @(negedge clk);
      for (int i = 0; i < 3; i++) tick();
      for (int k = 0; k < 3; k++) begin
         chk("rst_grant", int'(gnt[k]), 0);
         chk("rst_valid", int'(gv[k]), 0);
         chk("rst_timeout", int'(tmo[k]), 0);
      end

      // Fixed-priority release, RR rotation with timeouts, and no-timeout hold in parallel.
      rst_n = 1'b1;
      req_a = 4'b0110; req_b = 4'b1111; req_c = 4'b0001;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (c == 0) begin
            chk("fix_first_grant", int'(gnt[0]), 4);
            chk("fix_first_id", int'(gid[0]), 2);
            chk("pin_model_owner", m_owner[0], 2);
            req_a = 4'b0010;
         end else if (c == 1) begin
            chk("fix_gap", int'(gnt[0]), 0);
         end else if (c == 2) begin
            chk("fix_second_grant", int'(gnt[0]), 2);
            chk("fix_second_id", int'(gid[0]), 1);
         end
         if (c < 21) begin
            chk("rr_rot_grant", int'(gnt[1]), (c % 5 < 4) ? (1 << ((c / 5) % 4)) : 0);
            chk("rr_rot_timeout", int'(tmo[1]), (c % 5 == 4) ? 1 : 0);
         end
         chk("nohold_grant", int'(gnt[2]), 1);
         chk("nohold_timeout", int'(tmo[2]), 0);
      end

      // Round-robin pointer wraps from 3 to 0.
      rst_n = 1'b0;
      req_a = 4'b0000; req_b = 4'b0000; req_c = 4'b0000;
      tick();
      rst_n = 1'b1;
      req_b = 4'b1000;
      tick();
      chk("wrap_grant3", int'(gnt[1]), 8);
      req_b = 4'b0000;
      tick();
      chk("wrap_gap", int'(gnt[1]), 0);
      chk("pin_model_ptr", m_ptr[1], 0);
      req_b = 4'b1001;
      tick();
      chk("wrap_grant0", int'(gnt[1]), 1);
      chk("wrap_id0", int'(gid[1]), 0);

      // Asynchronous reset in the middle of a grant.
      req_a = 4'b0010;
      tick();
      chk("mid_grant", int'(gnt[0]), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_clear_grant", int'(gnt[0]), 0);
      chk("async_clear_valid", int'(gv[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("after_rst_grant", int'(gnt[0]), 2);

      // Randomized traffic with sticky requests so holds and timeouts occur.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 3) == 0) req_a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) req_b = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) req_c = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         tick();
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
